// File: rtl/adder_19.sv
// Registered 3-bit + 3-bit unsigned adder producing a 4-bit sum.
// Operands are captured on in_valid; the result and out_valid appear one cycle later.
module adder_19 (
  input  logic clk,
  input  logic rst,
  input  logic pi5,
  input  logic pi4,
  input  logic pi3,
  input  logic pi2,
  input  logic pi1,
  input  logic pi0,
  input  logic in_valid,
  output logic po3,
  output logic po2,
  output logic po1,
  output logic po0,
  output logic out_valid
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned SUM_W = OP_W + 1;

  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic [OP_W:0]    carry_c;
  logic [SUM_W-1:0] sum_c;
  logic [SUM_W-1:0] sum_q;
  logic             valid_q;

  assign op_a = {pi5, pi4, pi3};
  assign op_b = {pi2, pi1, pi0};

  // Ripple-carry chain; the final carry becomes the sum MSB.
  always_comb begin
    carry_c = '0;
    sum_c   = '0;
    for (int i = 0; i < int'(OP_W); i++) begin
      sum_c[i]     = op_a[i] ^ op_b[i] ^ carry_c[i];
      carry_c[i+1] = (op_a[i] & op_b[i]) | (carry_c[i] & (op_a[i] ^ op_b[i]));
    end
    sum_c[OP_W] = carry_c[OP_W];
  end

  // Result register: reset wins over a capture; idle cycles hold the last sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q <= sum_c;
      end
    end
  end

  assign po3       = sum_q[3];
  assign po2       = sum_q[2];
  assign po1       = sum_q[1];
  assign po0       = sum_q[0];
  assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_19.sv
// Self-checking bench for adder_19: directed vectors with literal expectations
// plus a cycle-by-cycle comparison against an arithmetic reference model.
`timescale 1ns/1ps
module tb_adder_19;

  logic clk = 1'b0;
  logic rst;
  logic pi5, pi4, pi3, pi2, pi1, pi0;
  logic in_valid;
  logic po3, po2, po1, po0;
  logic out_valid;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int   m_sum   = 0;
  logic m_valid = 1'b0;
  bit   m_known = 1'b0;

  adder_19 dut (
    .clk       (clk),
    .rst       (rst),
    .pi5       (pi5),
    .pi4       (pi4),
    .pi3       (pi3),
    .pi2       (pi2),
    .pi1       (pi1),
    .pi0       (pi0),
    .in_valid  (in_valid),
    .po3       (po3),
    .po2       (po2),
    .po1       (po1),
    .po0       (po0),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Model: outputs after an edge follow directly from the inputs at that edge.
  always @(posedge clk) begin
    if (rst) begin
      m_sum   = 0;
      m_valid = 1'b0;
      m_known = 1'b1;
    end else if (in_valid) begin
      m_sum   = int'({pi5, pi4, pi3}) + int'({pi2, pi1, pi0});
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  end

  // Compare DUT against the model mid-cycle, once reset has defined the outputs.
  always @(negedge clk) begin
    if (m_known) begin
      tests++;
      if ({po3, po2, po1, po0} !== 4'(m_sum) || out_valid !== m_valid) begin
        fails++;
        $display("FAIL model_cmp t=%0t: got sum=%b valid=%b, expected sum=%b valid=%b",
                 $time, {po3, po2, po1, po0}, out_valid, 4'(m_sum), m_valid);
      end
    end
  end

  // Apply one cycle of stimulus; returns just after the capturing edge.
  task automatic step(input logic [5:0] v, input logic iv, input logic r);
    {pi5, pi4, pi3, pi2, pi1, pi0} = v;
    in_valid = iv;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] exp_s, input logic exp_v);
    tests++;
    if ({po3, po2, po1, po0} !== exp_s || out_valid !== exp_v) begin
      fails++;
      $display("FAIL %s: got sum=%b valid=%b, expected sum=%b valid=%b",
               name, {po3, po2, po1, po0}, out_valid, exp_s, exp_v);
    end
  endtask

  initial begin
    logic [5:0] v;
    logic [3:0] e;

    {pi5, pi4, pi3, pi2, pi1, pi0} = 6'b0;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    step(6'b111111, 1'b1, 1'b1);
    check("reset", 4'b0000, 1'b0);

    // First edge after reset release accepts operands
    step(6'b000000, 1'b1, 1'b0);
    check("zero", 4'b0000, 1'b1);
    step(6'b111111, 1'b1, 1'b0);
    check("max_7p7", 4'b1110, 1'b1);
    step(6'b100100, 1'b1, 1'b0);
    check("carry_4p4", 4'b1000, 1'b1);
    step(6'b011100, 1'b1, 1'b0);
    check("nocarry_3p4", 4'b0111, 1'b1);

    // Exhaustive, back-to-back
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      e = 4'(i / 8) + 4'(i % 8);
      step(v, 1'b1, 1'b0);
      check("exhaustive", e, 1'b1);
    end

    // Hold while idle
    step(6'b101011, 1'b1, 1'b0);
    check("hold_load", 4'b1000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(6'b111111, 1'b0, 1'b0);
      check("hold_idle", 4'b1000, 1'b0);
    end

    // Mid-stream reset has priority over in_valid
    step(6'b111111, 1'b1, 1'b0);
    check("pre_reset", 4'b1110, 1'b1);
    step(6'b000001, 1'b1, 1'b1);
    check("reset_prio", 4'b0000, 1'b0);
    step(6'b000001, 1'b1, 1'b0);
    check("post_reset", 4'b0001, 1'b1);

    // Streaming
    step(6'b001001, 1'b1, 1'b0);
    check("stream0", 4'b0010, 1'b1);
    step(6'b010010, 1'b1, 1'b0);
    check("stream1", 4'b0100, 1'b1);
    step(6'b011011, 1'b1, 1'b0);
    check("stream2", 4'b0110, 1'b1);
    step(6'b011011, 1'b0, 1'b0);
    check("stream_end", 4'b0110, 1'b0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000ns");
    $fatal(1);
  end

endmodule
